// File: rtl/load_store_unit_if.sv
// Bundles the CPU-side request/response and the data-memory port of the load/store unit.
// The slave modport is the LSU's view; master is the control unit and memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic [5:0]  OP;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, OP, addr, wdata, mem_ack, mem_rdata,
    output busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, OP, addr, wdata, mem_ack, mem_rdata,
    input  busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine: decodes width/sign, checks alignment, runs a
// req/ack memory access (or read-modify-write for sub-word stores) and extends loads.
module load_store_unit #(
  parameter bit BYTE_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave lsu
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_RMW_RD = 3'd2,
    S_RMW_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic f_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW: f_legal = 1'b1;
      default:                                                   f_legal = 1'b0;
    endcase
  endfunction

  function automatic logic f_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_LH, OP_LHU, OP_SH: f_misaligned = a[0];
      OP_LW, OP_SW:         f_misaligned = (a != 2'b00);
      default:              f_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic f_is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: f_is_store = 1'b1;
      default:             f_is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   f_be = 4'b0001 << a;
      OP_SH:   f_be = 4'b0011 << a;
      OP_SW:   f_be = 4'b1111;
      default: f_be = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_wlanes(input logic [5:0] op, input logic [31:0] wd);
    case (op)
      OP_SB:   f_wlanes = {4{wd[7:0]}};
      OP_SH:   f_wlanes = {2{wd[15:0]}};
      default: f_wlanes = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [5:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {a, 3'b000};
    case (op)
      OP_LB:   f_extend = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  f_extend = {24'h000000, sh[7:0]};
      OP_LH:   f_extend = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  f_extend = {16'h0000, sh[15:0]};
      default: f_extend = rd;
    endcase
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] lanes,
                                          input logic [3:0] be);
    for (int k = 0; k < 4; k++) begin
      f_merge[8*k +: 8] = be[k] ? lanes[8*k +: 8] : old[8*k +: 8];
    end
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [5:0]  r_op;
  logic [1:0]  r_lane;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;

  logic        w_bad;
  logic        w_rmw;
  logic [5:0]  w_op_sel;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_we_nxt;

  assign w_bad    = !f_legal(lsu.OP) || f_misaligned(lsu.OP, lsu.addr[1:0]);
  assign w_rmw    = !BYTE_EN && ((lsu.OP == OP_SB) || (lsu.OP == OP_SH));
  assign w_op_sel = (r_state == S_IDLE) ? lsu.OP : r_op;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!lsu.req_valid) begin
          w_next_state = S_IDLE;
        end else if (w_bad) begin
          w_next_state = S_DONE;
        end else if (w_rmw) begin
          w_next_state = S_RMW_RD;
        end else begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: w_next_state = lsu.mem_ack ? S_DONE   : S_ACCESS;
      S_RMW_RD: w_next_state = lsu.mem_ack ? S_RMW_WR : S_RMW_RD;
      S_RMW_WR: w_next_state = lsu.mem_ack ? S_DONE   : S_RMW_WR;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Outputs for the state being entered; registered below so every output is a flop.
  // Only an error path goes IDLE->DONE directly, which is what flags err.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    w_we_nxt   = 1'b0;
    case (w_next_state)
      S_ACCESS: begin
        w_busy_nxt = 1'b1;
        w_we_nxt   = f_is_store(w_op_sel);
      end
      S_RMW_RD: w_busy_nxt = 1'b1;
      S_RMW_WR: begin
        w_busy_nxt = 1'b1;
        w_we_nxt   = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
        w_err_nxt  = (r_state == S_IDLE);
      end
      default: w_busy_nxt = 1'b0;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= 6'b000000;
      r_lane      <= 2'b00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
    end else begin
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_mem_req <= w_busy_nxt;
      r_mem_we  <= w_we_nxt;
      case (r_state)
        S_IDLE: begin
          if (lsu.req_valid && !w_bad) begin
            r_op        <= lsu.OP;
            r_lane      <= lsu.addr[1:0];
            r_mem_addr  <= {lsu.addr[31:2], 2'b00};
            r_mem_be    <= w_rmw ? 4'b0000 : f_be(lsu.OP, lsu.addr[1:0]);
            r_mem_wdata <= f_wlanes(lsu.OP, lsu.wdata);
          end
        end
        S_ACCESS: begin
          if (lsu.mem_ack && !f_is_store(r_op)) begin
            r_rdata <= f_extend(r_op, r_lane, lsu.mem_rdata);
          end
        end
        // r_mem_wdata already holds the replicated store lanes from acceptance
        S_RMW_RD: begin
          if (lsu.mem_ack) begin
            r_mem_wdata <= f_merge(lsu.mem_rdata, r_mem_wdata, f_be(r_op, r_lane));
            r_mem_be    <= 4'b1111;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu.busy      = r_busy;
  assign lsu.done      = r_done;
  assign lsu.err       = r_err;
  assign lsu.rdata     = r_rdata;
  assign lsu.mem_req   = r_mem_req;
  assign lsu.mem_we    = r_mem_we;
  assign lsu.mem_addr  = r_mem_addr;
  assign lsu.mem_be    = r_mem_be;
  assign lsu.mem_wdata = r_mem_wdata;

endmodule
